// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC owner, in-order imem request/response, instruction buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef enum logic {BOOT, FETCH} state_t;
  state_t state_q, state_d;

  logic [31:0]   buf_data [FIFO_DEPTH];
  logic [31:0]   buf_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] kill;

  logic          grant;
  logic          pop;
  logic          push;
  logic [31:0]   target;
  logic [OW-1:0] outstanding_d;
  logic [PW-1:0] rd_ptr_n;
  logic [CW-1:0] remain;
  logic [SW-1:0] pending;
  logic          head_valid_d;
  logic [31:0]   head_data_d;
  logic [31:0]   head_pc_d;

  assign grant         = imem_req & imem_gnt;
  assign pop           = instr_valid & instr_ready;
  // A word returning in the redirect cycle is stale even when kill is still zero.
  assign push          = imem_rvalid & ~redirect & (kill == '0);
  assign target        = {redirect_pc[31:2], 2'b00};
  assign outstanding_d = outstanding + OW'(grant) - OW'(imem_rvalid);
  assign rd_ptr_n      = rd_ptr + PW'(pop);
  assign remain        = count - CW'(pop);
  assign pending       = SW'(count) + SW'(outstanding) - SW'(pop);
  assign imem_addr     = fetch_pc;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = (pending < SW'(FIFO_DEPTH)) && (outstanding < OW'(MAX_OUTSTANDING));
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Registered head mirrors the buffer state after this edge's push/pop.
  always_comb begin
    head_valid_d = 1'b0;
    head_data_d  = NOP;
    head_pc_d    = '0;
    if (!redirect) begin
      if (remain != '0) begin
        head_valid_d = 1'b1;
        head_data_d  = buf_data[rd_ptr_n];
        head_pc_d    = buf_pc[rd_ptr_n];
      end else if (push) begin
        head_valid_d = 1'b1;
        head_data_d  = imem_rdata;
        head_pc_d    = resp_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      misaligned  <= 1'b0;
    end else begin
      outstanding <= outstanding_d;
      misaligned  <= redirect & (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        kill     <= outstanding_d;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
        end
        if (imem_rvalid && (kill != '0)) begin
          kill <= kill - OW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= '0;
    end else begin
      instr_valid <= head_valid_d;
      instr       <= head_data_d;
      instr_pc    <= head_pc_d;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= rd_ptr_n;
        count  <= remain + CW'(push);
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with queue-based memory and fetch model
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit live; } ofl_t;
  typedef struct { bit req; logic [31:0] addr; bit valid; logic [31:0] pc; } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gnt_pct = 100;
  int          last_due = 0;
  mreq_t       mem_q[$];
  ofl_t        ofl_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] m_pc = '0;
  int          m_age = 0;
  bit          m_mis = 1'b0;
  vec_t        tbl[8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h00C0_FFEE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    ofl_q.delete();
    fifo_q.delete();
    last_due = 0;
    m_pc = 32'h0;
    m_age = 0;
    m_mis = 1'b0;
  endtask

  // One clock: compare at negedge, advance memory and model, drive next inputs after the edge.
  task automatic step(input bit use_v, input vec_t v);
    bit          m_req, m_pop, g_dut, g_m, rv, full_push;
    int          due;
    ofl_t        e;
    logic [31:0] tgt;
    @(negedge clk);
    m_pop = (fifo_q.size() > 0) && instr_ready;
    m_req = (m_age >= 1) && ((fifo_q.size() + ofl_q.size() - int'(m_pop)) < 2) && (ofl_q.size() < 2);
    chk("imem_req", 32'(imem_req), 32'(m_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(fifo_q.size() > 0));
    chk("instr_pc", instr_pc, (fifo_q.size() > 0) ? fifo_q[0] : 32'h0);
    chk("instr", instr, (fifo_q.size() > 0) ? mem_word(fifo_q[0]) : NOP);
    chk("misaligned", 32'(misaligned), 32'(m_mis));
    full_push = (dut.count == 2) && imem_rvalid && (dut.kill == 0) && !redirect;
    chk("push_when_full", 32'(full_push), 32'd0);
    if (use_v) begin
      chk("tbl_req", 32'(imem_req), 32'(v.req));
      chk("tbl_addr", imem_addr, v.addr);
      chk("tbl_valid", 32'(instr_valid), 32'(v.valid));
      chk("tbl_pc", instr_pc, v.pc);
      chk("tbl_instr", instr, v.valid ? mem_word(v.pc) : NOP);
    end
    rv = imem_rvalid;
    if (rv && (mem_q.size() > 0)) void'(mem_q.pop_front());
    g_dut = imem_req && imem_gnt;
    if (g_dut) begin
      due = cyc + 1 + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: imem_addr, due: due});
    end
    g_m = m_req && imem_gnt;
    if (redirect) begin
      fifo_q.delete();
      if (rv && (ofl_q.size() > 0)) void'(ofl_q.pop_front());
      foreach (ofl_q[i]) ofl_q[i].live = 1'b0;
      if (g_m) ofl_q.push_back('{pc: m_pc, live: 1'b0});
      tgt = redirect_pc;
      m_pc = {tgt[31:2], 2'b00};
      m_mis = (tgt[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      if (m_pop) void'(fifo_q.pop_front());
      if (rv && (ofl_q.size() > 0)) begin
        e = ofl_q.pop_front();
        if (e.live) fifo_q.push_back(e.pc);
      end
      if (g_m) begin
        ofl_q.push_back('{pc: m_pc, live: 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_age < 8) m_age++;
    @(posedge clk);
    cyc++;
    #1;
    imem_rvalid = (mem_q.size() > 0) && (mem_q[0].due <= cyc + 1);
    imem_rdata  = imem_rvalid ? mem_word(mem_q[0].addr) : $urandom;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    redirect    = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    imem_rvalid = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    imem_gnt = ($urandom_range(99) < gnt_pct);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && (n < 40)) begin
      step(1'b0, tbl[0]);
      n++;
    end
    chk(name, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    tbl[0] = '{req: 1'b0, addr: 32'h00, valid: 1'b0, pc: 32'h00};
    tbl[1] = '{req: 1'b1, addr: 32'h00, valid: 1'b0, pc: 32'h00};
    tbl[2] = '{req: 1'b1, addr: 32'h04, valid: 1'b0, pc: 32'h00};
    tbl[3] = '{req: 1'b1, addr: 32'h08, valid: 1'b1, pc: 32'h00};
    tbl[4] = '{req: 1'b1, addr: 32'h0C, valid: 1'b1, pc: 32'h04};
    tbl[5] = '{req: 1'b1, addr: 32'h10, valid: 1'b1, pc: 32'h08};
    tbl[6] = '{req: 1'b1, addr: 32'h14, valid: 1'b1, pc: 32'h0C};
    tbl[7] = '{req: 1'b1, addr: 32'h18, valid: 1'b1, pc: 32'h10};

    lat = 1;
    gnt_pct = 100;
    instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, tbl[k]);

    instr_ready = 1'b0;
    repeat (5) step(1'b0, tbl[0]);
    chk("bp_req_low", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    repeat (6) step(1'b0, tbl[0]);

    lat = 4;
    for (int n = 0; (n < 20) && (ofl_q.size() != 2); n++) step(1'b0, tbl[0]);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    step(1'b0, tbl[0]);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    wait_valid("redir_wait_valid");
    chk("redir_first_pc", instr_pc, 32'h0000_0100);

    lat = 1;
    repeat (8) step(1'b0, tbl[0]);
    chk("coincide_precond", {30'd0, imem_req, imem_rvalid}, 32'd3);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    step(1'b0, tbl[0]);
    wait_valid("coincide_wait_valid");
    chk("coincide_first_pc", instr_pc, 32'h0000_0200);
    chk("coincide_first_instr", instr, mem_word(32'h0000_0200));

    repeat (3) step(1'b0, tbl[0]);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    step(1'b0, tbl[0]);
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_addr", imem_addr, 32'h0000_0100);
    step(1'b0, tbl[0]);
    chk("mis_clear", 32'(misaligned), 32'd0);
    wait_valid("mis_wait_valid");
    chk("mis_first_pc", instr_pc, 32'h0000_0100);

    instr_ready = 1'b0;
    repeat (4) step(1'b0, tbl[0]);
    chk("full_before_reset", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, tbl[k]);

    for (int r = 0; r < 6; r++) begin
      lat = 1 + (r % 4);
      gnt_pct = (r == 0) ? 100 : 40 + int'($urandom_range(60));
      repeat (1500) begin
        instr_ready = ($urandom_range(99) < 70);
        if ($urandom_range(99) < 4) begin
          redirect = 1'b1;
          case ($urandom_range(3))
            0: redirect_pc = $urandom;
            1: redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
            2: redirect_pc = $urandom & 32'h0000_0FFF;
            default: redirect_pc = 32'h0000_0100;
          endcase
        end
        step(1'b0, tbl[0]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached with %0d failures", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the RV32I decoder.
- Owns the architectural PC and issues word requests to instruction memory over a request/grant plus in-order response handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Consumes the decoder's redirect (PC_select / PC_branch) to flush the buffer and squash in-flight fetches.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch word address, bits[1:0] always 00
imem_gnt  in  1  request accepted this cycle (handshake = imem_req & imem_gnt)
imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant
imem_rdata  in  32  response instruction word
redirect  in  1  decoder PC_select: take redirect_pc
redirect_pc  in  32  decoder PC_branch target
instr_valid  out  1  FIFO head valid toward decoder
instr  out  32  FIFO head instruction; 32'h00000013 (NOP) when instr_valid=0
instr_pc  out  32  PC of FIFO head; 0 when empty
instr_ready  in  1  decoder consumes head (pop = instr_valid & instr_ready)
misaligned  out  1  one-cycle pulse: redirect_pc[1:0]!=0 was received

Behaviour:
Reset (async assert, sync release):
- Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP, instr_pc=0, misaligned=0.
- State: FIFO empty, outstanding=0, kill=0, FSM=BOOT.
- Reset mid-operation drops all buffered and in-flight state. Responses arriving after reset release for pre-reset requests are the memory's responsibility; the bench resets memory together with this block.

FSM:
- BOOT: one cycle, no request -> FETCH.
- FETCH: normal operation; no other states.

Issue rule:
- imem_req=1 iff (fifo_count + outstanding - pop) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
- On grant: fetch_pc += 4 (32-bit wrap, 32'hFFFFFFFC -> 0) and outstanding += 1.
- imem_addr and imem_req are held stable while req=1 and gnt=0, except in the cycle after a redirect.

Response:
- imem_rvalid with kill=0: push {imem_rdata, pc} to FIFO and decrement outstanding. The FIFO's own PC counter tracks the PC of the next returning response.
- imem_rvalid with kill>0: discard the word, decrement kill and outstanding.

Throughput: with a 1-cycle memory, instr_ready held high and no redirects, one instruction per cycle. The first instr_valid appears on the 3rd rising edge after reset release.

Redirect (sampled at the edge):
- Clear FIFO.
- fetch_pc = {redirect_pc[31:2],2'b00}; response PC tracker set to the same value.
- kill = outstanding + (grant this cycle) - (rvalid this cycle).
- Pop in the same cycle is legal: it is the branching instruction itself.
- A grant in the redirect cycle is to the old PC and is counted into kill.
- An rvalid in the redirect cycle is discarded regardless of kill.
- The next request carries the new target the cycle after the redirect.
- If redirect_pc[1:0]!=0: misaligned=1 for the next cycle and fetch continues from the aligned address.

FIFO:
- Push and pop in the same cycle with the FIFO full is legal; count unchanged.
- Push never occurs when full; the issue rule guarantees this. The bench asserts it.
- Pointers wrap modulo FIFO_DEPTH.
- instr, instr_valid and instr_pc are registered from FIFO storage; the head updates the cycle after a pop or push.

Counters: outstanding and kill are clog2(MAX_OUTSTANDING)+1 bits. kill <= outstanding always.

Test Plan:
1. Zero-wait memory (gnt=1, rvalid 1 cycle later), RESET_PC=0, instr_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; instr_pc 0,4,8 with matching words from cycle 3; no bubbles.
2. Backpressure: instr_ready=0 for 5 cycles -> FIFO fills to 2, imem_req drops once outstanding+count=2; on release, pcs continue with no loss or duplication.
3. Redirect with 2 responses in flight (4-cycle memory latency) and redirect_pc=32'h00000100 -> both stale responses discarded, next imem_addr=0x100, first instr_pc=0x100.
4. Redirect coincident with grant and rvalid in the same cycle -> kill counts the new grant but not the returning word; no stale instruction ever reaches instr_valid.
5. redirect_pc=32'h00000102 -> misaligned pulses 1 cycle, fetch resumes at 0x100.
6. reset_n asserted mid-stream with FIFO full -> all outputs take reset values immediately; after release, fetch restarts at RESET_PC via the BOOT cycle.
